mips_reset_seq: RTL and testbench
=================================

# mips_reset_seq

Parametrised reset sequencer placed between the board-level reset and the pipelined MIPS core with its memories and peripherals. Takes one asynchronous active-low reset, synchronises its release, holds every downstream domain in reset for a programmable number of cycles, then releases NUM_CH active-high channel resets in staggered order. Also supports software-requested re-reset and counts completed reset sequences. Generalises the fixed "hold reset 100 ns, then release" bring-up into a synthesizable, multi-channel block.

## Interface
Parameters:
- NUM_CH, 3: number of downstream reset channels (≥1); channel 0 is released first.
- HOLD_CYCLES, 10: cycles all channels stay asserted after the synchronised release (≥1).
- STAGGER, 2: cycles between consecutive channel releases (≥0; 0 releases all channels together).
- CNT_W, 8: width of the completed-sequence counter.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset; assertion takes effect immediately, deassertion is synchronised internally.
- sw_req  in  1  synchronous one-cycle request to re-run the sequence.
- rst_out  out  NUM_CH  per-channel active-high reset to downstream logic.
- ready  out  1  high when every channel is released.
- rst_count  out  CNT_W  completed sequences, saturating at all-ones.
- state  out  2  current FSM state, for debug.

## Operation
- States: ASSERT=0, HOLD=1, RELEASE=2, RUN=3.
- reset low (async): rst_out all ones, ready 0, state ASSERT, hold/stagger counters 0, rst_count 0, synchroniser flops 0.
- Synchroniser: two flops clocked by clk, async-cleared by reset, D of first = 1; output rst_sync_n.
- ASSERT: stays while rst_sync_n=0; on rst_sync_n=1 → HOLD, hold counter cleared.
- HOLD: hold counter increments each cycle; after HOLD_CYCLES cycles → RELEASE, rst_out[0] cleared on the same edge.
- RELEASE: channel i cleared STAGGER cycles after channel i-1; released channels stay low. When channel NUM_CH-1 clears → RUN, ready=1, rst_count increments on that edge (saturating).
- STAGGER=0 or NUM_CH=1: all channels clear on the HOLD exit edge; RELEASE occupies zero cycles (direct HOLD→RUN).
- sw_req in RUN, HOLD or RELEASE: next edge sets rst_out all ones, ready 0, state HOLD, hold counter 0; synchroniser bypassed. Incomplete sequences do not count.
- sw_req in ASSERT: ignored.
- Async reset assertion in any state overrides everything, including a same-cycle sw_req.

## Timing
- Reset deasserted before edge 1 → rst_sync_n high at edge 2 (= E). State HOLD from edge E+1.
- Channel i released at edge E+1+HOLD_CYCLES+i·STAGGER; ready and rst_count update at the last channel's edge.
- Defaults: ch0 at E+11, ch1 at E+13, ch2 at E+15, ready at E+15.
- sw_req sampled high at edge S: rst_out all ones and ready 0 after S; ch0 released at S+HOLD_CYCLES.
- rst_out, ready and state are registered outputs; no combinational path from inputs.

## Structure
- Package mips_rst_pkg: state encoding constants (ASSERT, HOLD, RELEASE, RUN) and the 2-bit state type.
- Sub-module reset_sync_2ff: two-flop release synchroniser with async active-low clear, reusable by other domains.
- Counter widths derived with $clog2 of HOLD_CYCLES and STAGGER (minimum 1 bit).

## Test plan
- Power-up, defaults: reset low 10 cycles, then high → rst_out=3'b111 through E+10; 3'b110 at E+11; 3'b100 at E+13; 3'b000 with ready=1 and rst_count=1 at E+15.
- Async assert mid-RELEASE: reset low between edges at E+12 → rst_out=3'b111, ready=0, rst_count=0 immediately, without a clock edge.
- sw_req in RUN: pulse at edge S → rst_out=3'b111 after S; ch0 at S+10, ready at S+14; rst_count 1→2.
- sw_req during HOLD at hold count 5 → counter restarts; ch0 released 10 cycles after the request; rst_count unchanged until completion.
- STAGGER=0, NUM_CH=4: all four channels and ready rise together at E+11; state goes HOLD→RUN.
- CNT_W=2: five consecutive sw_req sequences → rst_count saturates at 3.

Source files
------------

// File: rtl/mips_rst_pkg.sv
// Shared types for the MIPS reset sequencer: FSM state encoding and counter sizing.
package mips_rst_pkg;

    typedef enum logic [1:0] {
        ASSERT  = 2'd0,
        HOLD    = 2'd1,
        RELEASE = 2'd2,
        RUN     = 2'd3
    } state_t;

    // Width of a counter that must reach n-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reset_sync_2ff.sv
// Two-flop reset release synchroniser: assertion is asynchronous, release is
// delayed two clk edges so downstream logic never sees a metastable deassert.
module reset_sync_2ff (
    input  logic clk,
    input  logic reset,
    output logic rst_sync_n
);

    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], 1'b1};
        end
    end

    assign rst_sync_n = sync_q[1];

endmodule

// File: rtl/mips_reset_seq.sv
// Reset sequencer for the MIPS core: holds all channels in reset after a synchronised
// release, then frees them one by one, and counts completed sequences.
module mips_reset_seq
    import mips_rst_pkg::*;
#(
    parameter int unsigned NUM_CH      = 3,
    parameter int unsigned HOLD_CYCLES = 10,
    parameter int unsigned STAGGER     = 2,
    parameter int unsigned CNT_W       = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sw_req,
    output logic [NUM_CH-1:0] rst_out,
    output logic              ready,
    output logic [CNT_W-1:0]  rst_count,
    output logic [1:0]        state
);

    localparam int unsigned        HOLD_W    = cnt_width(HOLD_CYCLES);
    localparam int unsigned        STG_W     = cnt_width(STAGGER);
    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [STG_W-1:0]   STG_LAST  = STG_W'((STAGGER > 0) ? STAGGER - 1 : 0);
    // With no stagger (or a single channel) everything is freed on the HOLD exit edge.
    localparam bit                 DIRECT    = (STAGGER == 0) || (NUM_CH == 1);
    localparam logic [CNT_W-1:0]   CNT_MAX   = '1;

    logic rst_sync_n;

    state_t              state_q, state_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [STG_W-1:0]    stg_q, stg_d;
    logic [NUM_CH-1:0]   rst_q, rst_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_CH-1:0]   rst_shift;
    logic [CNT_W-1:0]    cnt_inc;

    reset_sync_2ff u_sync (
        .clk        (clk),
        .reset      (reset),
        .rst_sync_n (rst_sync_n)
    );

    // Channels are freed lowest first by shifting zeros in from bit 0.
    assign rst_shift = rst_q << 1;
    assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        stg_d   = stg_q;
        rst_d   = rst_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            ASSERT: begin
                if (rst_sync_n) begin
                    state_d = HOLD;
                    hold_d  = '0;
                end
            end
            HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    stg_d = '0;
                    if (DIRECT) begin
                        rst_d   = '0;
                        state_d = RUN;
                        cnt_d   = cnt_inc;
                    end else begin
                        rst_d   = rst_shift;
                        state_d = RELEASE;
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            RELEASE: begin
                if (stg_q == STG_LAST) begin
                    stg_d = '0;
                    rst_d = rst_shift;
                    if (rst_shift == '0) begin
                        state_d = RUN;
                        cnt_d   = cnt_inc;
                    end
                end else begin
                    stg_d = stg_q + 1'b1;
                end
            end
            RUN: begin
            end
            default: begin
                state_d = ASSERT;
            end
        endcase

        // A software re-reset restarts the hold phase; the synchroniser is already released.
        if (sw_req && (state_q != ASSERT)) begin
            state_d = HOLD;
            hold_d  = '0;
            stg_d   = '0;
            rst_d   = '1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ASSERT;
            hold_q  <= '0;
            stg_q   <= '0;
            rst_q   <= '1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            stg_q   <= stg_d;
            rst_q   <= rst_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rst_out   = rst_q;
    assign ready     = (state_q == RUN);
    assign rst_count = cnt_q;
    assign state     = state_q;

endmodule

// File: tb/tb_mips_reset_seq.sv
// Directed bench for mips_reset_seq: three parameterisations share one reset; expected
// per-edge values are queued from the release timing formula and compared after each edge.
module tb_mips_reset_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       sw_a, sw_b, sw_c;
    logic [2:0] ro_a, ro_c;
    logic [3:0] ro_b;
    logic       rdy_a, rdy_b, rdy_c;
    logic [7:0] cnt_a, cnt_b;
    logic [1:0] cnt_c;
    logic [1:0] st_a, st_b, st_c;

    mips_reset_seq dut_a (
        .clk       (clk),
        .reset     (reset),
        .sw_req    (sw_a),
        .rst_out   (ro_a),
        .ready     (rdy_a),
        .rst_count (cnt_a),
        .state     (st_a)
    );

    mips_reset_seq #(.NUM_CH(4), .STAGGER(0)) dut_b (
        .clk       (clk),
        .reset     (reset),
        .sw_req    (sw_b),
        .rst_out   (ro_b),
        .ready     (rdy_b),
        .rst_count (cnt_b),
        .state     (st_b)
    );

    mips_reset_seq #(.CNT_W(2)) dut_c (
        .clk       (clk),
        .reset     (reset),
        .sw_req    (sw_c),
        .rst_out   (ro_c),
        .ready     (rdy_c),
        .rst_count (cnt_c),
        .state     (st_c)
    );

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int         id;
        int         cyc;
        logic [3:0] ro;
        logic       rdy;
        logic [7:0] cnt;
        logic [1:0] st;
        string      tag;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Still in ASSERT: all channels held, nothing counted.
    function automatic void push_pre(input int id, input int n, input int cyc, input string tag);
        exp_t e;
        e.id  = id;
        e.cyc = cyc;
        e.ro  = 4'((1 << n) - 1);
        e.rdy = 1'b0;
        e.cnt = 8'd0;
        e.st  = 2'd0;
        e.tag = tag;
        sb.push_back(e);
    endfunction

    // Sequence whose HOLD phase starts (count 0) at edge h: channel i frees at h+10+i*st.
    function automatic void push_seq(input int id, input int n, input int st, input int h,
                                     input int pc, input int sat, input int from, input int to,
                                     input string tag);
        int last;
        int nc;
        last = h + 10 + (n - 1) * st;
        nc   = (pc + 1 > sat) ? sat : pc + 1;
        for (int c = from; c <= to; c++) begin
            exp_t e;
            e.id  = id;
            e.cyc = c;
            e.ro  = '0;
            for (int i = 0; i < n; i++) e.ro[i] = (c < h + 10 + i * st);
            e.rdy = (c >= last);
            e.cnt = 8'((c >= last) ? nc : pc);
            e.st  = (c < h + 10) ? 2'd1 : (c < last) ? 2'd2 : 2'd3;
            e.tag = tag;
            sb.push_back(e);
        end
    endfunction

    task automatic tick();
        logic [3:0] o_ro;
        logic       o_rdy;
        logic [7:0] o_cnt;
        logic [1:0] o_st;
        @(posedge clk);
        #1;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == edge_n) begin
                case (sb[i].id)
                    0: begin
                        o_ro = {1'b0, ro_a}; o_rdy = rdy_a; o_cnt = cnt_a; o_st = st_a;
                    end
                    1: begin
                        o_ro = ro_b; o_rdy = rdy_b; o_cnt = cnt_b; o_st = st_b;
                    end
                    default: begin
                        o_ro = {1'b0, ro_c}; o_rdy = rdy_c; o_cnt = {6'd0, cnt_c}; o_st = st_c;
                    end
                endcase
                chk($sformatf("%s.rst_out@%0d", sb[i].tag, edge_n), 32'(o_ro), 32'(sb[i].ro));
                chk($sformatf("%s.ready@%0d", sb[i].tag, edge_n), 32'(o_rdy), 32'(sb[i].rdy));
                chk($sformatf("%s.count@%0d", sb[i].tag, edge_n), 32'(o_cnt), 32'(sb[i].cnt));
                chk($sformatf("%s.state@%0d", sb[i].tag, edge_n), 32'(o_st), 32'(sb[i].st));
                sb.delete(i);
            end
        end
    endtask

    initial begin
        int e, h, s, s1, s2, pc;
        reset = 1'b1;
        sw_a  = 1'b0;
        sw_b  = 1'b0;
        sw_c  = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("async_pwr_a.rst_out", 32'(ro_a), 32'(3'b111));
        chk("async_pwr_a.ready", 32'(rdy_a), 32'(1'b0));

        // Power-up with defaults, plus STAGGER=0/NUM_CH=4 and CNT_W=2 variants alongside.
        repeat (10) tick();
        chk("rst_a.rst_out", 32'(ro_a), 32'(3'b111));
        chk("rst_a.ready", 32'(rdy_a), 32'(1'b0));
        chk("rst_a.count", 32'(cnt_a), 32'(0));
        chk("rst_a.state", 32'(st_a), 32'(0));
        chk("rst_b.rst_out", 32'(ro_b), 32'(4'hf));
        chk("rst_c.count", 32'(cnt_c), 32'(0));
        reset = 1'b1;
        e = edge_n + 2;
        h = e + 1;
        push_pre(0, 3, e - 1, "pwr_a");
        push_pre(0, 3, e, "pwr_a");
        push_pre(1, 4, e - 1, "pwr_b");
        push_pre(1, 4, e, "pwr_b");
        push_pre(2, 3, e, "pwr_c");
        push_seq(0, 3, 2, h, 0, 255, h, h + 16, "pwr_a");
        push_seq(1, 4, 0, h, 0, 255, h, h + 16, "pwr_b");
        push_seq(2, 3, 2, h, 0, 3, h, h + 16, "pwr_c");
        while (edge_n < h + 16) tick();

        // Software re-reset from RUN.
        s = edge_n + 1;
        push_seq(0, 3, 2, s, 1, 255, s, s + 15, "swrun_a");
        push_seq(1, 4, 0, s, 1, 255, s, s + 15, "swrun_b");
        sw_a = 1'b1;
        sw_b = 1'b1;
        tick();
        sw_a = 1'b0;
        sw_b = 1'b0;
        while (edge_n < s + 15) tick();

        // Re-request while HOLD count is 5: the hold restarts, the aborted run is not counted.
        s1 = edge_n + 1;
        push_seq(0, 3, 2, s1, 2, 255, s1, s1 + 5, "swhold1_a");
        sw_a = 1'b1;
        tick();
        sw_a = 1'b0;
        while (edge_n < s1 + 5) tick();
        s2 = edge_n + 1;
        push_seq(0, 3, 2, s2, 2, 255, s2, s2 + 15, "swhold2_a");
        sw_a = 1'b1;
        tick();
        sw_a = 1'b0;
        while (edge_n < s2 + 15) tick();

        // Two-bit counter saturates at 3.
        pc = 1;
        for (int k = 0; k < 5; k++) begin
            s = edge_n + 1;
            push_seq(2, 3, 2, s, pc, 3, s, s + 15, $sformatf("sat%0d_c", k));
            sw_c = 1'b1;
            tick();
            sw_c = 1'b0;
            while (edge_n < s + 15) tick();
            pc = (pc < 3) ? pc + 1 : 3;
        end
        chk("sat_c.final", 32'(cnt_c), 32'(3));

        // Second power-up: sw_req held during ASSERT must be ignored.
        reset = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        sw_a  = 1'b1;
        e = edge_n + 2;
        h = e + 1;
        push_pre(0, 3, e - 1, "asrt_a");
        push_pre(0, 3, e, "asrt_a");
        push_seq(0, 3, 2, h, 0, 255, h, e + 12, "rel_a");
        tick();
        tick();
        sw_a = 1'b0;
        while (edge_n < e + 12) tick();

        // Async assertion mid-RELEASE takes effect with no clock edge.
        #2 reset = 1'b0;
        #1;
        chk("midrel_a.rst_out", 32'(ro_a), 32'(3'b111));
        chk("midrel_a.ready", 32'(rdy_a), 32'(1'b0));
        chk("midrel_a.count", 32'(cnt_a), 32'(0));
        chk("midrel_a.state", 32'(st_a), 32'(0));
        chk("midrel_b.rst_out", 32'(ro_b), 32'(4'hf));
        chk("midrel_c.count", 32'(cnt_c), 32'(0));
        repeat (2) tick();
        chk("scoreboard_leftover", 32'(sb.size()), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
